// File: rtl/subseq_pkg.sv
// Shared definitions for the max-subsequence-sum engine and its frame feeder.
package subseq_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_LEN  = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned TIMEOUT    = 200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/subseq_frame_feeder_fifo.sv
// Synchronous FIFO with registered pointers and occupancy; no pop-through.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/subseq_frame_feeder.sv
// Buffers a sample stream and issues FRAME_LEN-sample frames to the
// subsequence-sum engine, one frame in flight, with a completion watchdog.
module subseq_frame_feeder #(
  parameter int unsigned DATA_W     = subseq_pkg::DATA_W,
  parameter int unsigned FRAME_LEN  = subseq_pkg::FRAME_LEN,
  parameter int unsigned FIFO_DEPTH = subseq_pkg::FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = subseq_pkg::TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          frame_valid,
  output logic [DATA_W-1:0]             frame_data,
  input  logic                          done_in,
  output logic [15:0]                   frame_count,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import subseq_pkg::*;

  localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nx;
  logic               pop;
  logic               count_inc;
  logic               err_set;
  logic               full;
  logic               empty;
  logic [DATA_W-1:0]  head;
  logic [LVL_W-1:0]   level;

  assign in_ready   = !full;
  assign fifo_level = level;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Next-state logic. The first sample is popped on the same edge that
  // leaves IDLE so frame_valid rises the cycle after the level check;
  // cnt therefore counts samples already popped rather than starting at 0.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    timer_nx  = timer;
    pop       = 1'b0;
    count_inc = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (level >= LVL_W'(FRAME_LEN) && !empty) begin
          pop      = 1'b1;
          cnt_nx   = CNT_W'(1);
          state_nx = SEND;
        end
      end
      SEND: begin
        if (cnt == CNT_W'(FRAME_LEN)) begin
          timer_nx = '0;
          state_nx = WAIT;
        end else begin
          pop    = 1'b1;
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (done_in) begin
          count_inc = 1'b1;
          state_nx  = IDLE;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered engine-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      timer       <= timer_nx;
      frame_valid <= pop;
      frame_data  <= pop ? head : '0;
      if (count_inc) frame_count <= frame_count + 16'd1;
      if (err_set)   timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_subseq_frame_feeder.sv
// Directed and randomized checks of subseq_frame_feeder against a
// queue-based behavioural model of the frame protocol.
module tb_subseq_frame_feeder;

  localparam int unsigned DW    = 8;
  localparam int unsigned FL    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        done_in;
  logic [15:0] frame_count;
  logic        timeout_err;
  logic [4:0]  fifo_level;

  subseq_frame_feeder #(
    .DATA_W     (DW),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .done_in     (done_in),
    .frame_count (frame_count),
    .timeout_err (timeout_err),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: buffered samples, what the engine is currently shown, and
  // whether we are emitting a frame (left>=0), awaiting done (waited>=0), or idle.
  logic [7:0]  m_q[$];
  int          m_left;
  int          m_waited;
  bit          m_fv;
  logic [7:0]  m_fd;
  logic [15:0] m_cnt;
  bit          m_err;
  logic [7:0]  got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit dn, input bit r, output bit acc);
    rst      = r;
    in_valid = v;
    in_data  = d;
    done_in  = dn;
    acc      = !r && v && (m_q.size() != DEPTH);
    if (r) begin
      m_q.delete();
      m_left = -1; m_waited = -1; m_fv = 0; m_fd = '0; m_cnt = '0; m_err = 0;
    end else begin
      if (m_left == 0) begin
        m_left = -1; m_waited = 0; m_fv = 0; m_fd = '0;
      end else if (m_left > 0) begin
        m_fd = m_q.pop_front(); m_left--;
      end else if (m_waited >= 0) begin
        if (dn) begin
          m_cnt++; m_waited = -1;
        end else if (m_waited == TMO - 1) begin
          m_err = 1; m_waited = -1;
        end else begin
          m_waited++;
        end
      end else if (m_q.size() >= FL) begin
        m_fd = m_q.pop_front(); m_fv = 1; m_left = FL - 1;
      end
      if (acc) m_q.push_back(d);
    end
    @(posedge clk);
    #1;
    if (frame_valid) got.push_back(frame_data);
    chk("frame_valid", frame_valid, m_fv);
    chk("frame_data",  frame_data,  m_fd);
    chk("in_ready",    in_ready,    m_q.size() != DEPTH);
    chk("fifo_level",  fifo_level,  m_q.size());
    chk("frame_count", frame_count, m_cnt);
    chk("timeout_err", timeout_err, m_err);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, a);
  endtask

  task automatic do_reset();
    bit a;
    step(1, 8'hAA, 0, 1, a);
    step(0, 8'h00, 0, 1, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit a;
    int n;
    int nfv;
    logic [7:0] nextv;
    logic [7:0] t1[8];
    t1 = '{8'hF9, 8'h01, 8'hFD, 8'h02, 8'hFF, 8'h01, 8'h03, 8'hFB};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; done_in = 1'b0;
    m_left = -1; m_waited = -1;

    // Reset state.
    do_reset();
    idle(1);
    chk("reset_ready", in_ready, 1);
    chk("reset_level", fifo_level, 0);

    // 1: one frame in push order, done three cycles after frame ends.
    got.delete();
    for (int i = 0; i < 8; i++) step(1, t1[i], 0, 0, a);
    n = 0;
    while (m_waited < 0 && n < 30) begin idle(1); n++; end
    idle(2);
    step(0, 8'h00, 1, 0, a);
    idle(2);
    chk("t1_len", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_order", got[i], t1[i]);
    chk("t1_count", frame_count, 1);
    chk("t1_err", timeout_err, 0);

    // 2: seven samples never start a frame; the eighth does.
    do_reset();
    got.delete();
    for (int i = 0; i < 7; i++) step(1, 8'(i + 40), 0, 0, a);
    idle(50);
    chk("t2_level", fifo_level, 7);
    chk("t2_nosend", got.size(), 0);
    step(1, 8'd47, 0, 0, a);
    idle(12);
    chk("t2_sent", got.size(), 8);

    // 3/6: continuous push, back-pressure when full, then a frame while full.
    do_reset();
    got.delete();
    nextv = 8'd1;
    for (int i = 0; i < 40; i++) begin
      step(1, nextv, 0, 0, a);
      if (a) nextv++;
    end
    chk("t3_full_level", fifo_level, DEPTH);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_accepted", nextv, 25);
    step(1, nextv, 1, 0, a);
    if (a) nextv++;
    for (int i = 0; i < 12; i++) begin
      step(1, nextv, 0, 0, a);
      if (a) nextv++;
      if (frame_valid) chk("t6_level_const", fifo_level, DEPTH - 1);
    end
    chk("t3_len", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t3_order", got[i], i + 1);

    // 4: watchdog fires exactly TMO cycles after WAIT begins; next frame follows.
    do_reset();
    got.delete();
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, a);
    n = 0;
    while (!(got.size() == 8 && !frame_valid) && n < 40) begin idle(1); n++; end
    chk("t4_frame1", got.size(), 8);
    n = 0;
    while (!timeout_err && n < 300) begin idle(1); n++; end
    chk("t4_latency", n, TMO);
    chk("t4_count", frame_count, 0);
    idle(10);
    chk("t4_frame2", got.size(), 16);

    // 5: reset mid-frame, then a stray done has no effect.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, a);
    idle(10);
    step(0, 8'h00, 1, 0, a);
    chk("t5_count_pre", frame_count, 1);
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, a);
    nfv = 0; n = 0;
    while (nfv < 3 && n < 20) begin
      idle(1); n++;
      if (frame_valid) nfv++;
    end
    step(0, 8'h00, 0, 1, a);
    chk("t5_valid", frame_valid, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_count", frame_count, 0);
    step(0, 8'h00, 1, 0, a);
    idle(3);
    chk("t5_stray_count", frame_count, 0);
    chk("t5_stray_err", timeout_err, 0);

    // Randomized traffic with occasional done pulses and resets.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 299) == 0, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
